// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder for the MEM stage: one request at a time, fixed latency.
// Define DATA_MEMORY_TRACE_EN to log every performed store and every error access.
module data_memory_responder #(
  parameter int WORDS   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        reqValid,
  input  logic        reqWrite,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  input  logic [3:0]  reqByteEnable,
  output logic        reqReady,
  output logic        stallMEM,
  output logic        respValid,
  output logic [31:0] respReadData,
  output logic        respError
);

  localparam int          AW         = $clog2(WORDS);
  localparam int          CW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(WORDS) << 2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            write_q;
  logic [31:0]     addr_q, wdata_q;
  logic [3:0]      be_q;
  logic [31:0]     rdata_q, rdata_d;
  logic            error_q, error_d;
  logic [31:0]     mem_q [WORDS];

  logic            accept, perform, addr_err, mem_we;
  logic [AW-1:0]   idx;
  logic [31:0]     old_word, new_word;

  assign accept  = (state_q == IDLE) && reqValid;
  assign perform = (state_q == BUSY) && (cnt_q == '0);

  // State register: FSM, latency counter, latched request and response data.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      if (accept) begin
        write_q <= reqWrite;
        addr_q  <= reqAddress;
        wdata_q <= reqWriteData;
        be_q    <= reqByteEnable;
      end
    end
  end

  // Next-state logic.
  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (reqValid) begin
        state_d = BUSY;
        cnt_d   = CW'(LATENCY - 1);
      end
      BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access datapath: error decode, byte-lane merge and the response word.
  always_comb begin
    addr_err = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= ADDR_LIMIT);
    idx      = addr_q[AW+1:2];
    old_word = mem_q[idx];
    new_word = old_word;
    if (write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) new_word[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
    mem_we  = perform && write_q && !addr_err;
    rdata_d = rdata_q;
    error_d = error_q;
    if (perform) begin
      error_d = addr_err;
      rdata_d = addr_err ? 32'h0 : new_word;
    end
  end

  // NOTE: the array must read as zero after reset, so each word carries its own async clear.
  for (genvar g = 0; g < WORDS; g++) begin : g_word
    always_ff @(posedge clock or posedge reset) begin
      if (reset)                           mem_q[g] <= '0;
      else if (mem_we && idx == AW'(g))    mem_q[g] <= new_word;
    end
  end

  // Outputs: all registered-state decodes except the stall, which must react to reqValid.
  always_comb begin
    reqReady     = (state_q == IDLE);
    respValid    = (state_q == RESP);
    stallMEM     = accept || (state_q == BUSY);
    respReadData = rdata_q;
    respError    = error_q;
  end

`ifdef DATA_MEMORY_TRACE_EN
  always_ff @(posedge clock) begin
    if (!reset && perform) begin
      if (addr_err)     $display("MEMERR %h", addr_q);
      else if (write_q) $display("@%h: *%h <= %h", addr_q, {addr_q[31:2], 2'b00}, new_word);
    end
  end
`else
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: a reference word array predicts each response.
module tb_data_memory_responder;

  localparam int WORDS   = 1024;
  localparam int LATENCY = 2;
  localparam int AW      = $clog2(WORDS);

  logic        clock = 1'b0;
  logic        reset;
  logic        reqValid, reqWrite;
  logic [31:0] reqAddress, reqWriteData;
  logic [3:0]  reqByteEnable;
  logic        reqReady, stallMEM, respValid, respError;
  logic [31:0] respReadData;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] model [WORDS];
  int          checks = 0, errors = 0, nreq = 0, nresp = 0;

  logic        st_w  [4];
  logic [31:0] st_a  [4];
  logic [31:0] st_d  [4];
  logic [3:0]  st_be [4];

  data_memory_responder #(.WORDS(WORDS), .LATENCY(LATENCY)) dut (
    .clock        (clock),
    .reset        (reset),
    .reqValid     (reqValid),
    .reqWrite     (reqWrite),
    .reqAddress   (reqAddress),
    .reqWriteData (reqWriteData),
    .reqByteEnable(reqByteEnable),
    .reqReady     (reqReady),
    .stallMEM     (stallMEM),
    .respValid    (respValid),
    .respReadData (respReadData),
    .respError    (respError)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: applies the access to the model array and queues the expected response.
  task automatic push_expected(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be);
    resp_t       r;
    logic [31:0] word;
    if (a[1:0] != 2'b00 || a >= 32'(WORDS * 4)) begin
      r.data = 32'h0;
      r.err  = 1'b1;
    end else begin
      word = model[a[AW+1:2]];
      if (w) begin
        for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = d[8*i +: 8];
        model[a[AW+1:2]] = word;
      end
      r.data = word;
      r.err  = 1'b0;
    end
    sb.push_back(r);
    nreq++;
  endtask

  always @(negedge clock) begin
    resp_t e;
    if (!reset && respValid) begin
      nresp++;
      if (sb.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("resp_data", respReadData, e.data);
        check("resp_err", {31'd0, respError}, {31'd0, e.err});
      end
    end
  end

  // Presents one request, waits for acceptance, drops reqValid in the first BUSY cycle.
  task automatic send_nowait(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input bit exp_resp);
    bit got = 0;
    @(posedge clock); #1;
    reqValid = 1'b1; reqWrite = w; reqAddress = a; reqWriteData = d; reqByteEnable = be;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (reqReady) begin got = 1; break; end
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    check("stall_on_req", {31'd0, stallMEM}, 32'd1);
    if (exp_resp) push_expected(w, a, d, be);
    @(posedge clock); #1;
    reqValid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
    @(negedge clock);
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be);
    send_nowait(w, a, d, be, 1'b1);
    wait_drain();
  endtask

  initial begin
    int  k, last;
    bit  accepted;

    reqValid = 0; reqWrite = 0; reqAddress = 0; reqWriteData = 0; reqByteEnable = 0;
    for (int i = 0; i < WORDS; i++) model[i] = 32'h0;
    st_w[0] = 1; st_a[0] = 32'h8; st_d[0] = 32'h1111_1111; st_be[0] = 4'b1111;
    st_w[1] = 0; st_a[1] = 32'h8; st_d[1] = 32'h0;         st_be[1] = 4'b1111;
    st_w[2] = 1; st_a[2] = 32'hC; st_d[2] = 32'hA5A5_A5A5; st_be[2] = 4'b1100;
    st_w[3] = 0; st_a[3] = 32'hC; st_d[3] = 32'h0;         st_be[3] = 4'b0000;

    reset = 1'b1;
    #12;
    check("rst_ready", {31'd0, reqReady}, 32'd1);
    check("rst_stall", {31'd0, stallMEM}, 32'd0);
    check("rst_valid", {31'd0, respValid}, 32'd0);
    check("rst_data", respReadData, 32'h0);
    check("rst_err", {31'd0, respError}, 32'd0);
    @(negedge clock); reset = 1'b0;

    // Timed load: stall in cycles 0-2, response in cycle LATENCY+1.
    send_nowait(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
    for (int c = 1; c <= LATENCY; c++) begin
      @(negedge clock);
      check("busy_stall", {31'd0, stallMEM}, 32'd1);
      check("busy_ready", {31'd0, reqReady}, 32'd0);
      check("busy_valid", {31'd0, respValid}, 32'd0);
    end
    @(negedge clock);
    check("resp_cycle_valid", {31'd0, respValid}, 32'd1);
    check("resp_cycle_stall", {31'd0, stallMEM}, 32'd0);
    wait_drain();

    // Full-word store, lane store, empty-lane store.
    send(1'b1, 32'h20, 32'hDEAD_BEEF, 4'b1111);
    send(1'b0, 32'h20, 32'h0, 4'b1111);
    send(1'b1, 32'h20, 32'h0000_00AA, 4'b0001);
    send(1'b0, 32'h20, 32'h0, 4'b0000);
    send(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000);
    send(1'b1, 32'h24, 32'h0102_0304, 4'b0110);

    // Misaligned and out-of-range accesses must not touch the array.
    send(1'b0, 32'h22, 32'h0, 4'b1111);
    send(1'b0, 32'h1000, 32'h0, 4'b1111);
    send(1'b1, 32'h22, 32'h5555_5555, 4'b1111);
    send(1'b1, 32'h0000_1020, 32'h6666_6666, 4'b1111);
    send(1'b1, 32'hFFFF_FFFC, 32'h7777_7777, 4'b1111);
    send(1'b0, 32'h20, 32'h0, 4'b1111);
    send(1'b0, 32'hFFC, 32'h0, 4'b1111);

    // Continuous reqValid with alternating store/load.
    @(posedge clock); #1;
    k = 0; last = -1;
    reqValid = 1'b1; reqWrite = st_w[0]; reqAddress = st_a[0];
    reqWriteData = st_d[0]; reqByteEnable = st_be[0];
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clock);
      if (reqValid) check("stream_stall", {31'd0, stallMEM}, {31'd0, !respValid});
      accepted = 0;
      if (reqValid && reqReady) begin
        push_expected(reqWrite, reqAddress, reqWriteData, reqByteEnable);
        if (last >= 0) check("stream_gap", 32'(cyc - last), 32'(LATENCY + 2));
        last = cyc;
        k++;
        accepted = 1;
      end
      @(posedge clock); #1;
      if (accepted) begin
        if (k < 4) begin
          reqWrite = st_w[k]; reqAddress = st_a[k];
          reqWriteData = st_d[k]; reqByteEnable = st_be[k];
        end else begin
          reqValid = 1'b0;
        end
      end
      if (k == 4 && !reqValid) break;
    end
    check("stream_count", 32'(k), 32'd4);
    wait_drain();

    // Reset during BUSY discards the pending store and clears the array.
    send_nowait(1'b1, 32'h40, 32'h1234_5678, 4'b1111, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_ready", {31'd0, reqReady}, 32'd1);
    check("midrst_stall", {31'd0, stallMEM}, 32'd0);
    check("midrst_valid", {31'd0, respValid}, 32'd0);
    check("midrst_data", respReadData, 32'h0);
    check("midrst_err", {31'd0, respError}, 32'd0);
    for (int i = 0; i < WORDS; i++) model[i] = 32'h0;
    @(negedge clock); reset = 1'b0;
    repeat (6) @(negedge clock);
    send(1'b0, 32'h40, 32'h0, 4'b1111);
    send(1'b0, 32'h20, 32'h0, 4'b1111);
    send(1'b0, 32'hC, 32'h0, 4'b1111);

    check("sb_empty", sb.size(), 32'd0);
    check("resp_count", 32'(nresp), 32'(nreq));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the MEM-stage data-memory interface: accepts one load/store request at a time from the Memory stage, services it after a fixed access latency from an internal word array, and returns one response pulse.
- Drives a stall flag that is OR-ed into the pipeline stall alongside stallID/stallEX while an access is outstanding.
- Replaces the zero-latency data memory in the CPU top level so that multi-cycle memory timing can be exercised.

Parameters:
- WORDS, 1024, number of 32-bit words in the array; power of two, ≥4.
- LATENCY, 2, BUSY cycles before the access is performed; must be ≥1.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- reqValid  in  1  request present from the MEM stage
- reqWrite  in  1  1 = store, 0 = load
- reqAddress  in  32  byte address
- reqWriteData  in  32  store data
- reqByteEnable  in  4  store byte lanes; bit i selects bits [8i+7:8i]; ignored for loads
- reqReady  out  1  responder can accept a request this cycle
- stallMEM  out  1  pipeline must hold
- respValid  out  1  one-cycle response pulse
- respReadData  out  32  load data, held until the next response
- respError  out  1  qualified by respValid; misaligned or out-of-range access

Behaviour:
- Reset (asynchronous, active-high, any state):
  - State goes to IDLE and the counter to 0.
  - reqReady=1, stallMEM=0, respValid=0, respReadData=0, respError=0.
  - Latched request is dropped; a pending store is never performed.
  - Array is cleared to zero.
- State IDLE:
  - reqReady=1.
  - On a clock edge with reqValid=1: latch reqWrite, reqAddress, reqWriteData and reqByteEnable, load counter=LATENCY-1, go to BUSY.
- State BUSY:
  - reqReady=0.
  - Each edge: if counter≠0, decrement it; if counter=0, perform the access and go to RESP.
  - Input changes during BUSY, including reqValid dropping, are ignored.
- Access rules:
  - Word index = latched reqAddress[log2(WORDS)+1:2].
  - Error when reqAddress[1:0]≠0 or reqAddress ≥ WORDS*4. On error: no write, respReadData=0, respError=1.
  - Store: the array word is updated only in enabled byte lanes. reqByteEnable=0000 completes normally with no change. respReadData takes the post-write word.
  - Load: respReadData takes the full word.
- State RESP:
  - respValid=1 for exactly one cycle; next edge returns to IDLE.
  - A new request can be accepted at the first IDLE edge, so back-to-back requests are separated by one IDLE cycle.
- stallMEM is combinational: stallMEM = (IDLE && reqValid) || BUSY.
  - stallMEM=0 during RESP, so the pipeline advances in the same cycle it samples respReadData.
- Timing: if a request is present in cycle T (IDLE), respValid is high in cycle T+LATENCY+1.
- There is no response backpressure; the consumer must sample in the RESP cycle.
- Outputs come from registered state except stallMEM.

Optional Feature:
- Macro: DATA_MEMORY_TRACE_EN.
- When defined: at each performed store, $display one line "@%h: *%h <= %h". The fields are the latched address, the word-aligned address and the post-write word. For error accesses, display "MEMERR %h" instead.
- When undefined: no display statements; RTL is otherwise identical and the port list is unchanged.

Test Plan:
- Reset, then load from 0x0000_0010 with reqValid in cycle 0 → stallMEM=1 in cycles 0–2, respValid=1 in cycle 3 (LATENCY=2), respReadData=0x0000_0000, respError=0.
- Store 0xDEADBEEF to 0x20 with byteEnable 1111, then load 0x20 → second respReadData=0xDEADBEEF. Then store 0x000000AA with byteEnable 0001 and load 0x20 → respReadData=0xDEADBEAA.
- Load at 0x22 and load at 0x1000 (WORDS=1024) → each gives respError=1, respReadData=0; array unchanged.
- Store 0x12345678 to 0x40 and assert reset during BUSY → all outputs 0 and reqReady=1 immediately; a subsequent load of 0x40 returns 0x00000000.
- Hold reqValid high continuously with alternating store/load at 0x8 and 0xC → requests are accepted every LATENCY+2 cycles, one respValid per request, and stallMEM=0 only in RESP cycles.
- Compile with DATA_MEMORY_TRACE_EN and store 0xCAFEF00D to 0x4 → log shows "@00000004: *00000004 <= cafef00d"; without the macro nothing is printed.
